universal_counter: RTL and testbench
====================================

Name: universal_counter

Overview:
Parametrised general-purpose counter for the FSM/timer library. Replaces the fixed free-running binary counter with:
- a runtime-programmable terminal count
- up/down direction
- parallel load
- a clock-enable prescaler
- three modes: wrap, saturate, one-shot timer with a start/busy/done handshake

Used for baud/tick generation, debounce timers and bounded event counting.

Parameters:
N, 8, counter width in bits
PW, 4, prescale field width in bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  count enable, feeds the prescaler
up  in  1  1 = count up, 0 = count down
load  in  1  parallel load strobe
d  in  N  load value
limit  in  N  terminal count; counting range is 0..limit
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap
start  in  1  one-shot trigger, sampled only in IDLE
prescale  in  PW  one step every prescale+1 enabled cycles
q  out  N  count value, registered
max_tick  out  1  combinational (q >= limit)
min_tick  out  1  combinational (q == 0)
busy  out  1  high while the one-shot FSM is in RUN
done  out  1  one-cycle pulse while the FSM is in DONE

Behaviour:
- Reset and priority:
  - Reset: q=0, prescaler pcnt=0, FSM=IDLE, busy=0, done=0.
  - Priority is reset > load > start > step.
- Prescaler:
  - pcnt is PW bits and advances only when en=1.
  - step=1 when en=1 and pcnt==prescale; pcnt then returns to 0, otherwise pcnt increments.
  - prescale=0 gives step on every enabled cycle. en=0 holds pcnt.
  - load and start clear pcnt.
- Load: q <= min(d, limit) on the next edge, in every mode. In one-shot mode, load also forces the FSM to IDLE (abort).
- Wrap mode, on step:
  - up: q >= limit gives 0, else q+1.
  - down: q == 0 gives limit, else q-1.
- Saturate mode, on step:
  - up: q >= limit gives limit, else q+1.
  - down: q == 0 holds 0, else q-1.
- One-shot FSM (only active when mode=10):
  - IDLE: steps are ignored and q holds. start=1 loads q with 0 (up) or limit (down), then goes to RUN.
  - RUN: busy=1 and steps count as in saturate mode. A step whose next q equals the terminal (limit if up, 0 if down), or a step while q is already terminal, goes to DONE. start is ignored.
  - DONE: done=1, busy=0, q holds the terminal value. Goes unconditionally to IDLE next cycle. start is ignored.
- Leaving mode 10 while in RUN or DONE forces IDLE at the next edge.
- Outside one-shot mode, the FSM stays IDLE with busy=0 and done=0.
- limit changed below q at runtime: the next step in wrap-up or saturate-up corrects q (0 or limit respectively); down counting proceeds normally.
- limit=0:
  - q stays 0 in wrap and saturate modes; max_tick=min_tick=1.
  - One-shot: the first step after start goes to DONE.
- direction or prescale may change on any cycle; the new value takes effect on that cycle's step.
- All arithmetic is modulo 2^N with no overflow outputs.
- Latency: q changes on the clock edge at which the step, load or start is sampled.

Test Plan:
1. Wrap up, N=8, limit=9, prescale=0, en=1 after reset → q=0,1,…,9,0,1; max_tick high only while q=9 (1 cycle in 10); min_tick high while q=0.
2. Wrap down, limit=5, prescale=2 → q changes every 3rd enabled cycle: 0→5→4→3; dropping en for 4 cycles mid-period delays the next change by exactly 4 cycles.
3. Saturate, limit=3, up=1 → q=0,1,2,3,3,3; then up=0 → 2,1,0,0; mid-run limit set to 1 with q=3 and up=1 → next step gives q=1.
4. Load: d=200 with limit=100 → q=100; load=1 together with a step and d=7 → q=7, not 8; reset asserted together with load → q=0.
5. One-shot up, limit=4, prescale=0, en=1:
   - start at edge t → q=0, busy=1 from t.
   - q reaches 4 at edge t+4; done=1 and busy=0 for exactly one cycle, then IDLE.
   - q stays 4 until the next start.
   - A second start during RUN is ignored.
   - Repeat with a reset asserted mid-RUN → q=0, busy=0, and no done pulse.
6. One-shot with limit=0 → start, one step, done pulse, q=0; load asserted during RUN → FSM returns to IDLE with no done pulse and q=min(d, limit).

Source files
------------

// File: rtl/universal_counter.sv
// -----------------------------------------------------------------------------
// universal_counter
//
// General-purpose counter for the FSM/timer library. It supports a
// programmable terminal count, up/down direction, parallel load and a
// clock-enable prescaler. It has three modes:
//   00 / 11 : wrap
//   01      : saturate
//   10      : one-shot timer with a start/busy/done handshake
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        count enable, feeds the prescaler
//   up        1 = count up, 0 = count down
//   load      parallel load strobe; q <= min(d, limit)
//   d         load value
//   limit     terminal count; counting range is 0..limit
//   mode      counting mode (see above)
//   start     one-shot trigger, only honoured while the timer is idle
//   prescale  one count step every prescale+1 enabled cycles
//   q         registered count value
//   max_tick  q >= limit (combinational)
//   min_tick  q == 0 (combinational)
//   busy      one-shot timer is running
//   done      one-cycle pulse when the one-shot timer reaches its terminal
// -----------------------------------------------------------------------------
module universal_counter #(
   parameter int N  = 8,
   parameter int PW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          up,
   input  logic          load,
   input  logic [N-1:0]  d,
   input  logic [N-1:0]  limit,
   input  logic [1:0]    mode,
   input  logic          start,
   input  logic [PW-1:0] prescale,
   output logic [N-1:0]  q,
   output logic          max_tick,
   output logic          min_tick,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [N-1:0]  ONE_Q = 1;
   localparam logic [PW-1:0] ONE_P = 1;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  q_next;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_next;
   logic          step;
   logic          one_shot;
   logic          start_take;
   logic [N-1:0]  load_val;
   logic [N-1:0]  terminal;
   logic [N-1:0]  wrap_val;
   logic [N-1:0]  sat_val;

   assign one_shot   = (mode == 2'b10);
   assign step       = en && (pcnt == prescale);
   // A start only counts when the timer can actually accept it.
   assign start_take = one_shot && (state == IDLE) && start;
   assign load_val   = (d > limit) ? limit : d;
   assign terminal   = up ? limit : '0;

   assign max_tick = (q >= limit);
   assign min_tick = (q == '0);

   // Candidate next values for one step in each counting style. The ">="
   // comparisons also pull q back into range when limit is lowered below it.
   always_comb begin
      wrap_val = q;
      sat_val  = q;
      if (up) begin
         wrap_val = (q >= limit) ? '0    : q + ONE_Q;
         sat_val  = (q >= limit) ? limit : q + ONE_Q;
      end else begin
         wrap_val = (q == '0) ? limit : q - ONE_Q;
         sat_val  = (q == '0) ? '0    : q - ONE_Q;
      end
   end

   // Prescaler. It free-runs on enabled cycles and restarts its period on
   // load or an accepted start, so the first step after either is a full
   // period away.
   always_comb begin
      pcnt_next = pcnt;
      if (load || start_take) begin
         pcnt_next = '0;
      end else if (en) begin
         pcnt_next = step ? '0 : pcnt + ONE_P;
      end
   end

   // Next-state, next-count and handshake outputs. Load overrides everything
   // (and aborts a running timer). Outside one-shot mode the FSM is held idle.
   always_comb begin
      state_next = state;
      q_next     = q;
      busy       = (state == RUN);
      done       = (state == DONE);
      if (load) begin
         q_next     = load_val;
         state_next = IDLE;
      end else if (!one_shot) begin
         state_next = IDLE;
         if (step) begin
            q_next = (mode == 2'b01) ? sat_val : wrap_val;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q_next     = up ? '0 : limit;
                  state_next = RUN;
               end
            end
            RUN: begin
               // A step already sitting on the terminal also lands here,
               // since saturation keeps it there.
               if (step) begin
                  q_next = sat_val;
                  if (sat_val == terminal) begin
                     state_next = DONE;
                  end
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State, count and prescaler registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         q     <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_next;
         q     <= q_next;
         pcnt  <= pcnt_next;
      end
   end

endmodule

// File: tb/tb_universal_counter.sv
// -----------------------------------------------------------------------------
// tb_universal_counter
//
// Self-checking bench for universal_counter. A behavioural model tracks the
// expected count, prescaler position and timer phase. A negedge process
// compares every output against it on each cycle. Directed sequences also
// pin key values with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_universal_counter;

   localparam int N  = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          up;
   logic          load;
   logic [N-1:0]  d;
   logic [N-1:0]  limit;
   logic [1:0]    mode;
   logic          start;
   logic [PW-1:0] prescale;
   logic [N-1:0]  q;
   logic          max_tick;
   logic          min_tick;
   logic          busy;
   logic          done;

   int errors = 0;
   int checks = 0;
   bit checkOn = 1'b0;

   // Model state: expected count, prescaler position, and timer phase flags.
   int mq = 0;
   int mp = 0;
   bit mRun = 1'b0;
   bit mDone = 1'b0;

   always #5 clk = ~clk;

   universal_counter #(.N(N), .PW(PW)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .up(up),
      .load(load),
      .d(d),
      .limit(limit),
      .mode(mode),
      .start(start),
      .prescale(prescale),
      .q(q),
      .max_tick(max_tick),
      .min_tick(min_tick),
      .busy(busy),
      .done(done)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Behavioural model: applies the counter rules to integer state on each
   // rising edge, using the inputs presented during the preceding cycle.
   always @(posedge clk) begin
      int lim;
      bit stp;
      int nq;
      lim = int'(limit);
      stp = en && (mp == int'(prescale));
      if (reset) begin
         mq = 0;
         mp = 0;
         mRun = 1'b0;
         mDone = 1'b0;
      end else if (load) begin
         mq = (int'(d) < lim) ? int'(d) : lim;
         mp = 0;
         mRun = 1'b0;
         mDone = 1'b0;
      end else if (mode == 2'b10 && !mRun && !mDone && start) begin
         mq = up ? 0 : lim;
         mp = 0;
         mRun = 1'b1;
      end else begin
         if (en) mp = stp ? 0 : (mp + 1) % (1 << PW);
         if (up) nq = (mq >= lim) ? lim : mq + 1;
         else    nq = (mq == 0) ? 0 : mq - 1;
         if (mode == 2'b10) begin
            if (mDone) begin
               mDone = 1'b0;
            end else if (mRun && stp) begin
               mq = nq;
               if (mq == (up ? lim : 0)) begin
                  mRun = 1'b0;
                  mDone = 1'b1;
               end
            end
         end else begin
            mRun = 1'b0;
            mDone = 1'b0;
            if (stp) begin
               if (mode == 2'b01) mq = nq;
               else if (up)       mq = (mq >= lim) ? 0 : mq + 1;
               else               mq = (mq == 0) ? lim : mq - 1;
            end
         end
      end
   end

   // Compare every output against the model once per cycle, mid-period.
   always @(negedge clk) begin
      if (checkOn) begin
         checkOutput("q", q, mq);
         checkOutput("max_tick", max_tick, (mq >= int'(limit)));
         checkOutput("min_tick", min_tick, (mq == 0));
         checkOutput("busy", busy, mRun);
         checkOutput("done", done, mDone);
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
      limit = 8'd9; mode = 2'b00; start = 1'b0; prescale = '0;
      applyStimulus(2);
      reset = 1'b0;
      en = 1'b1;
      checkOn = 1'b1;
      checkOutput("reset_q", q, 0);
      checkOutput("reset_busy", busy, 0);

      // Wrap up to 9 and roll over.
      applyStimulus(9);
      checkOutput("wrap_up_q9", q, 9);
      checkOutput("wrap_up_max", max_tick, 1);
      applyStimulus(1);
      checkOutput("wrap_up_roll", q, 0);
      checkOutput("wrap_up_min", min_tick, 1);
      applyStimulus(1);
      checkOutput("wrap_up_q1", q, 1);

      // Wrap down with prescale 2 and an en gap.
      limit = 8'd5; up = 1'b0; prescale = 4'd2; load = 1'b1; d = 8'd0;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("wrap_dn_load0", q, 0);
      applyStimulus(2);
      checkOutput("wrap_dn_wait", q, 0);
      applyStimulus(1);
      checkOutput("wrap_dn_q5", q, 5);
      applyStimulus(3);
      checkOutput("wrap_dn_q4", q, 4);
      applyStimulus(1);
      en = 1'b0;
      applyStimulus(4);
      en = 1'b1;
      applyStimulus(1);
      checkOutput("wrap_dn_gap_hold", q, 4);
      applyStimulus(1);
      checkOutput("wrap_dn_q3", q, 3);

      // Saturate with a runtime limit drop.
      mode = 2'b01; limit = 8'd3; up = 1'b1; prescale = '0; load = 1'b1; d = 8'd0;
      applyStimulus(1);
      load = 1'b0;
      applyStimulus(5);
      checkOutput("sat_up_hold", q, 3);
      up = 1'b0;
      applyStimulus(4);
      checkOutput("sat_dn_hold", q, 0);
      up = 1'b1;
      applyStimulus(3);
      limit = 8'd1;
      applyStimulus(1);
      checkOutput("sat_limit_drop", q, 1);

      // Load clamping, load over step, and reset over load.
      mode = 2'b00; limit = 8'd100; d = 8'd200; load = 1'b1;
      applyStimulus(1);
      checkOutput("load_clamp", q, 100);
      d = 8'd7;
      applyStimulus(1);
      checkOutput("load_over_step", q, 7);
      reset = 1'b1; d = 8'd50;
      applyStimulus(1);
      reset = 1'b0; load = 1'b0;
      checkOutput("reset_over_load", q, 0);

      // One-shot up with limit 4.
      mode = 2'b10; limit = 8'd4; load = 1'b1; d = 8'd2;
      applyStimulus(1);
      load = 1'b0;
      applyStimulus(2);
      checkOutput("os_idle_hold", q, 2);
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("os_start_q", q, 0);
      checkOutput("os_start_busy", busy, 1);
      applyStimulus(1);
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("os_restart_ignored", q, 2);
      applyStimulus(2);
      checkOutput("os_term_q", q, 4);
      checkOutput("os_done", done, 1);
      checkOutput("os_done_busy", busy, 0);
      applyStimulus(1);
      checkOutput("os_done_gone", done, 0);
      applyStimulus(3);
      checkOutput("os_idle_after", q, 4);

      // Reset in the middle of a run.
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(2);
      checkOutput("os_mid_q", q, 2);
      reset = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      checkOutput("os_reset_q", q, 0);
      checkOutput("os_reset_busy", busy, 0);
      applyStimulus(5);

      // One-shot with limit 0.
      limit = 8'd0; start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("os_l0_busy", busy, 1);
      applyStimulus(1);
      checkOutput("os_l0_done", done, 1);
      checkOutput("os_l0_q", q, 0);
      applyStimulus(1);

      // Load aborts a run.
      limit = 8'd10; start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(2);
      load = 1'b1; d = 8'd20;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("os_abort_q", q, 10);
      checkOutput("os_abort_busy", busy, 0);
      applyStimulus(3);

      // One-shot counting down from limit.
      up = 1'b0; start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("os_dn_start", q, 10);
      applyStimulus(10);
      checkOutput("os_dn_done", done, 1);
      applyStimulus(1);

      // Leaving one-shot mode mid-run, then mode 11 acting as wrap.
      up = 1'b1; start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(3);
      mode = 2'b00;
      applyStimulus(1);
      checkOutput("os_leave_q", q, 4);
      checkOutput("os_leave_busy", busy, 0);
      mode = 2'b11; limit = 8'd2;
      applyStimulus(4);
      checkOutput("mode11_wrap", q, 0);

      applyStimulus(2);
      checkOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
